regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 The block SHALL have parameter w, default 8, which is the data width.
REQ-002 The block SHALL have parameter sel_w, default 4, which is the register select width.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-007 The block SHALL have port cmd_op, input, 3 bits: operation code.
REQ-008 The block SHALL have ports cmd_x, cmd_y and cmd_z, input, sel_w bits each: source A, source B and destination register indices.
REQ-009 The block SHALL have ports x_sel, y_sel and z_sel, output, sel_w bits each: register file select lines.
REQ-010 The block SHALL have ports x_enb, y_enb and z_enb, output, 1 bit each: register file strobes; the register file acts on their edges.
REQ-011 The block SHALL have ports x_in and y_in, input, w bits each: register file read data.
REQ-012 The block SHALL have port z_out, output, w bits: register file write data.
REQ-013 The block SHALL have port result, output, w bits: last computed value.
REQ-014 The block SHALL have ports carry and zero, output, 1 bit each: flags of the last operation.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 States SHALL be IDLE, RSETUP, READ, LATCH, EXEC, WSETUP, WRITE, WHOLD.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-018 On accept, the block SHALL register cmd_op, cmd_x, cmd_y and cmd_z, and the state SHALL go to RSETUP.
REQ-019 x_sel and y_sel SHALL be driven from the registered indices from RSETUP through LATCH inclusive, and SHALL be stable while x_enb and y_enb rise.
REQ-020 x_enb and y_enb SHALL be 1 only in READ (one cycle) and 0 in every other state.
REQ-021 x_in and y_in SHALL be captured into operand registers at the end of LATCH.
REQ-022 In EXEC, the result register SHALL be computed by op code: 0 MOV=A, 1 ADD=A+B, 2 SUB=A-B, 3 AND, 4 OR, 5 XOR, 6 NOT=~A, 7 CMP=A-B (no write-back).
REQ-023 ADD SHALL set carry to bit w of the (w+1)-bit sum; SUB and CMP SHALL set carry to 1 on borrow (A<B); all other ops SHALL clear carry; zero SHALL be (w-bit result == 0); flags SHALL update in EXEC only.
REQ-024 Arithmetic SHALL wrap modulo 2^w.
REQ-025 z_sel and z_out SHALL be driven from WSETUP through WHOLD inclusive, and SHALL be stable across both edges of z_enb.
REQ-026 z_enb SHALL be 1 only in WRITE (one cycle) and SHALL NOT be asserted for CMP.
REQ-027 For CMP, the state path SHALL be EXEC -> WSETUP -> WRITE -> WHOLD with z_enb held 0, so latency is identical for all ops.
REQ-028 done SHALL be 1 during WHOLD only; the next state after WHOLD SHALL be IDLE.
REQ-029 The latency SHALL be 7 clocks: an accept edge at cycle 0 gives done high in cycle 7, and the next accept is possible at cycle 8.
REQ-030 cmd_valid asserted outside IDLE SHALL be ignored; command inputs SHALL be sampled only at accept.
REQ-031 A read and a write to the same index in one command (cmd_x == cmd_z) SHALL be legal, because the read completes before WRITE.
REQ-032 In IDLE, all selects, z_out and all strobes SHALL be 0.

Reset
REQ-033 When reset is 1 at a clock edge, state SHALL become IDLE and x_enb, y_enb, z_enb, done, carry and zero SHALL become 0.
REQ-034 When reset is 1 at a clock edge, x_sel, y_sel, z_sel, z_out and result SHALL become 0, and cmd_ready SHALL be 1 on the following cycle.
REQ-035 A reset before WRITE SHALL abort the command with no register file write; a reset during WRITE SHALL drop z_enb on that edge, and the write that already occurred SHALL stand.
REQ-036 Reset SHALL take priority over a simultaneous cmd_valid.

Structure
REQ-037 A shared package SHALL hold the op-code constants (OP_MOV..OP_CMP), the state encoding and the default w and sel_w values.
REQ-038 There SHALL be one sub-module, regfile_alu: combinational, w-bit, inputs op/A/B, outputs result/carry/zero; the FSM SHALL stay in regfile_sequencer.

Verification
REQ-039 The bench SHALL cover: with a behavioural register file where R1=0x05 and R2=0x03, ADD x=1 y=2 z=4 -> R4=0x08, carry=0, zero=0, and done in cycle 7 after accept.
REQ-040 The bench SHALL cover: R1=0xFF, R2=0x01, ADD -> R4=0x00, carry=1, zero=1.
REQ-041 The bench SHALL cover: R1=0x02, R2=0x03, CMP -> carry=1, zero=0, z_enb never 1, and all registers unchanged.
REQ-042 The bench SHALL cover: cmd_valid held high for 3 back-to-back commands -> accepts 8 cycles apart, and every strobe rises with selects stable one cycle earlier.
REQ-043 The bench SHALL cover: reset asserted in EXEC -> no write, all outputs 0, and cmd_ready=1 on the next cycle.
REQ-044 The bench SHALL cover: SUB x=3 y=3 z=3 with R3=0x2A -> R3=0x00, zero=1, carry=0.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// rtl/regfile_sequencer_pkg.sv - shared op codes, state encoding and default widths
package regfile_sequencer_pkg;

    localparam int W_DEFAULT     = 8;
    localparam int SEL_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        OP_MOV = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_NOT = 3'd6,
        OP_CMP = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RSETUP = 3'd1,
        READ   = 3'd2,
        LATCH  = 3'd3,
        EXEC   = 3'd4,
        WSETUP = 3'd5,
        WRITE  = 3'd6,
        WHOLD  = 3'd7
    } state_t;

    // CMP walks the full write path for equal latency but never strobes the file.
    function automatic logic writes_back(input op_t op);
        return op != OP_CMP;
    endfunction

endpackage

// File: rtl/regfile_alu.sv
// rtl/regfile_alu.sv - combinational w-bit ALU with carry/borrow and zero flags
module regfile_alu
    import regfile_sequencer_pkg::*;
#(
    parameter int w = W_DEFAULT
) (
    input  op_t          op,
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic [w-1:0] result,
    output logic         carry,
    output logic         zero
);

    logic [w:0] sum;
    logic [w:0] diff;

    // The extra top bit of diff is the borrow, set exactly when a < b.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_MOV: result = a;
            OP_ADD: begin
                result = sum[w-1:0];
                carry  = sum[w];
            end
            OP_SUB, OP_CMP: begin
                result = diff[w-1:0];
                carry  = diff[w];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - sequences read, execute and write-back against an external register file
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int w     = W_DEFAULT,
    parameter int sel_w = SEL_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [sel_w-1:0] cmd_x,
    input  logic [sel_w-1:0] cmd_y,
    input  logic [sel_w-1:0] cmd_z,
    output logic [sel_w-1:0] x_sel,
    output logic [sel_w-1:0] y_sel,
    output logic [sel_w-1:0] z_sel,
    output logic             x_enb,
    output logic             y_enb,
    output logic             z_enb,
    input  logic [w-1:0]     x_in,
    input  logic [w-1:0]     y_in,
    output logic [w-1:0]     z_out,
    output logic [w-1:0]     result,
    output logic             carry,
    output logic             zero,
    output logic             done
);

    state_t           state;
    op_t              op_q;
    logic [sel_w-1:0] z_idx;
    logic [w-1:0]     a_q;
    logic [w-1:0]     b_q;

    logic [w-1:0]     alu_result;
    logic             alu_carry;
    logic             alu_zero;

    regfile_alu #(
        .w(w)
    ) u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .result(alu_result),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    // Every output is registered and set on the edge entering the state that owns it,
    // so selects are always one full cycle ahead of their strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_MOV;
            z_idx     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cmd_ready <= 1'b1;
            x_sel     <= '0;
            y_sel     <= '0;
            z_sel     <= '0;
            x_enb     <= 1'b0;
            y_enb     <= 1'b0;
            z_enb     <= 1'b0;
            z_out     <= '0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
        end else begin
            x_enb <= 1'b0;
            y_enb <= 1'b0;
            z_enb <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= op_t'(cmd_op);
                        x_sel     <= cmd_x;
                        y_sel     <= cmd_y;
                        z_idx     <= cmd_z;
                        cmd_ready <= 1'b0;
                        state     <= RSETUP;
                    end
                end
                RSETUP: begin
                    x_enb <= 1'b1;
                    y_enb <= 1'b1;
                    state <= READ;
                end
                READ: begin
                    state <= LATCH;
                end
                LATCH: begin
                    a_q   <= x_in;
                    b_q   <= y_in;
                    x_sel <= '0;
                    y_sel <= '0;
                    state <= EXEC;
                end
                EXEC: begin
                    result <= alu_result;
                    carry  <= alu_carry;
                    zero   <= alu_zero;
                    z_sel  <= z_idx;
                    z_out  <= alu_result;
                    state  <= WSETUP;
                end
                WSETUP: begin
                    z_enb <= writes_back(op_q);
                    state <= WRITE;
                end
                WRITE: begin
                    done  <= 1'b1;
                    state <= WHOLD;
                end
                WHOLD: begin
                    z_sel     <= '0;
                    z_out     <= '0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - randomized self-checking bench with a behavioural register file
module tb_regfile_sequencer;

    localparam int W    = 8;
    localparam int SW   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [SW-1:0] cmd_x = '0;
    logic [SW-1:0] cmd_y = '0;
    logic [SW-1:0] cmd_z = '0;
    logic [SW-1:0] x_sel, y_sel, z_sel;
    logic          x_enb, y_enb, z_enb;
    logic [W-1:0]  x_in = '0;
    logic [W-1:0]  y_in = '0;
    logic [W-1:0]  z_out, result;
    logic          carry, zero, done;

    always #5 clock = ~clock;

    regfile_sequencer #(.w(W), .sel_w(SW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
        .x_sel(x_sel), .y_sel(y_sel), .z_sel(z_sel),
        .x_enb(x_enb), .y_enb(y_enb), .z_enb(z_enb),
        .x_in(x_in), .y_in(y_in), .z_out(z_out),
        .result(result), .carry(carry), .zero(zero), .done(done)
    );

    // behavioural register file acting on strobe rising edges
    logic [W-1:0] rf [16];
    int           mrf[16];
    int           writes = 0;

    always @(posedge x_enb) x_in = rf[x_sel];
    always @(posedge y_enb) y_in = rf[y_sel];
    always @(posedge z_enb) begin
        rf[z_sel] = z_out;
        writes++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int acc_q[$];
    int done_q[$];
    int cur_x, cur_y, cur_z, cur_exp;
    int pend_exp, pend_c, pend_zr;

    always @(posedge clock) begin
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1 && reset === 1'b0) begin
            acc_q.push_back(cyc);
            cur_x   = int'(cmd_x);
            cur_y   = int'(cmd_y);
            cur_z   = int'(cmd_z);
            cur_exp = pend_exp;
        end
        cyc++;
    end

    logic          px_enb = 1'b0, pz_enb = 1'b0;
    logic [SW-1:0] px_sel = '0, py_sel = '0, pz_sel = '0;
    logic [W-1:0]  pz_out = '0;

    always @(negedge clock) begin
        if (x_enb === 1'b1 && px_enb !== 1'b1) begin
            check("x_sel_before_strobe", 32'(px_sel), 32'(cur_x));
            check("x_sel_at_strobe", 32'(x_sel), 32'(cur_x));
            check("y_sel_before_strobe", 32'(py_sel), 32'(cur_y));
            check("y_sel_at_strobe", 32'(y_sel), 32'(cur_y));
        end
        if (z_enb === 1'b1 && pz_enb !== 1'b1) begin
            check("z_sel_before_strobe", 32'(pz_sel), 32'(cur_z));
            check("z_out_before_strobe", 32'(pz_out), 32'(cur_exp));
            check("z_sel_at_strobe", 32'(z_sel), 32'(cur_z));
            check("z_out_at_strobe", 32'(z_out), 32'(cur_exp));
        end
        if (z_enb !== 1'b1 && pz_enb === 1'b1) begin
            check("z_sel_after_strobe", 32'(z_sel), 32'(cur_z));
            check("z_out_after_strobe", 32'(z_out), 32'(cur_exp));
        end
        if (done === 1'b1) done_q.push_back(cyc);
        px_enb = x_enb;
        pz_enb = z_enb;
        px_sel = x_sel;
        py_sel = y_sel;
        pz_sel = z_sel;
        pz_out = z_out;
    end

    function automatic void ref_op(input int op, input int a, input int b,
                                   output int r, output int c);
        c = 0;
        case (op)
            0: r = a;
            1: begin r = (a + b) % (MAXV + 1); c = (a + b > MAXV) ? 1 : 0; end
            2, 7: begin r = (a - b + MAXV + 1) % (MAXV + 1); c = (a < b) ? 1 : 0; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            default: r = MAXV - a;
        endcase
    endfunction

    task automatic set_reg(input int i, input int v);
        rf[i]  = W'(v);
        mrf[i] = v;
    endtask

    task automatic load_cmd(input int op, input int x, input int y, input int z, input bit commit);
        int r, c;
        ref_op(op, mrf[x], mrf[y], r, c);
        pend_exp = r;
        pend_c   = c;
        pend_zr  = (r == 0) ? 1 : 0;
        if (commit && op != 7) mrf[z] = r;
        cmd_op = 3'(op);
        cmd_x  = SW'(x);
        cmd_y  = SW'(y);
        cmd_z  = SW'(z);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait_bound", 32'(cmd_ready), 32'd1);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) check(tag, 32'(rf[i]), 32'(mrf[i]));
    endtask

    task automatic run_cmd(input int op, input int x, input int y, input int z);
        int w0, n0, d0, n;
        wait_ready();
        w0 = writes;
        n0 = acc_q.size();
        d0 = done_q.size();
        load_cmd(op, x, y, z, 1'b1);
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        check("accepted", 32'(acc_q.size()), 32'(n0 + 1));
        n = 0;
        while (done_q.size() == d0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("done_seen", 32'(done_q.size()), 32'(d0 + 1));
        if (done_q.size() > d0 && acc_q.size() > n0)
            check("latency", 32'(done_q[d0] - acc_q[n0]), 32'd7);
        check("result", 32'(result), 32'(pend_exp));
        check("carry", 32'(carry), 32'(pend_c));
        check("zero", 32'(zero), 32'(pend_zr));
        check("rf_dest", 32'(rf[z]), 32'(mrf[z]));
        check("write_count", 32'(writes - w0), (op == 7) ? 32'd0 : 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_strobes"}, {29'd0, x_enb, y_enb, z_enb}, 32'd0);
        check({tag, "_sels"}, {20'd0, x_sel, y_sel, z_sel}, 32'd0);
        check({tag, "_z_out"}, 32'(z_out), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_flags"}, {29'd0, carry, zero, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, n0, d0, n, base;
        int b2b[3][4];
        for (int i = 0; i < 16; i++) set_reg(i, int'($urandom_range(0, MAXV)));
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        set_reg(1, 8'h05); set_reg(2, 8'h03);
        run_cmd(1, 1, 2, 4);
        check("add_r4", 32'(rf[4]), 32'h08);

        set_reg(1, 8'hFF); set_reg(2, 8'h01);
        run_cmd(1, 1, 2, 4);
        check("add_wrap_r4", 32'(rf[4]), 32'h00);

        set_reg(1, 8'h02); set_reg(2, 8'h03);
        run_cmd(7, 1, 2, 4);
        check("cmp_carry", 32'(carry), 32'd1);
        check_all_regs("cmp_regs_unchanged");

        // abort in EXEC with a simultaneous command request
        wait_ready();
        w0 = writes;
        n0 = acc_q.size();
        set_reg(5, 8'h11); set_reg(6, 8'h22); set_reg(7, 8'h99);
        load_cmd(1, 5, 6, 7, 1'b0);
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clock);
        check_idle_outputs("abort");
        reset = 1'b0;
        cmd_valid = 1'b0;
        repeat (10) @(negedge clock);
        check("abort_writes", 32'(writes - w0), 32'd0);
        check("abort_r7", 32'(rf[7]), 32'h99);
        check("abort_accepts", 32'(acc_q.size()), 32'(n0 + 1));

        set_reg(3, 8'h2A);
        run_cmd(2, 3, 3, 3);
        check("sub_self_r3", 32'(rf[3]), 32'h00);

        // back-to-back with cmd_valid held high
        set_reg(1, 8'h40); set_reg(2, 8'hC5);
        b2b[0] = '{1, 1, 2, 8};
        b2b[1] = '{2, 8, 1, 9};
        b2b[2] = '{5, 9, 8, 8};
        wait_ready();
        base = acc_q.size();
        d0 = done_q.size();
        w0 = writes;
        load_cmd(b2b[0][0], b2b[0][1], b2b[0][2], b2b[0][3], 1'b1);
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (acc_q.size() <= base + k && n < 40) begin
                @(negedge clock);
                n++;
            end
            if (k < 2) load_cmd(b2b[k+1][0], b2b[k+1][1], b2b[k+1][2], b2b[k+1][3], 1'b1);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (done_q.size() < d0 + 3 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("b2b_accepts", 32'(acc_q.size() - base), 32'd3);
        check("b2b_dones", 32'(done_q.size() - d0), 32'd3);
        if (acc_q.size() >= base + 3 && done_q.size() >= d0 + 3) begin
            for (int k = 1; k < 3; k++)
                check("b2b_accept_spacing", 32'(acc_q[base+k] - acc_q[base+k-1]), 32'd8);
            for (int k = 0; k < 3; k++)
                check("b2b_latency", 32'(done_q[d0+k] - acc_q[base+k]), 32'd7);
        end
        check("b2b_writes", 32'(writes - w0), 32'd3);
        check("b2b_result", 32'(result), 32'(pend_exp));
        check("b2b_carry", 32'(carry), 32'(pend_c));
        check_all_regs("b2b_regs");

        for (int t = 0; t < 24; t++) begin
            if (($urandom & 3) == 0)
                set_reg(int'($urandom_range(0, 15)), int'($urandom_range(0, MAXV)));
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        check_all_regs("final_regs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
